// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flag derivation, two-entry skid buffer, delivery counter.
// Optional saturation on signed overflow when ALU_RESULT_SAT_EN is defined.
module alu_result_stage #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         co,
  input  logic [n-1:0] r,
  input  logic         xs,
  input  logic         ys,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] res,
  output logic         flag_z,
  output logic         flag_n,
  output logic         flag_c,
  output logic         flag_v,
  output logic [15:0]  count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t       state, state_next;
  logic         acc, dlv;
  logic         v_in, c_in;
  logic [n-1:0] r_fin;
  logic [n+3:0] ent_in, main_q, skid_q;
  logic         load_main, load_skid, pop_skid;

  assign acc  = in_valid & in_ready;
  assign dlv  = out_valid & out_ready;
  assign v_in = (xs == ys) & (r[n-1] != xs);
  assign c_in = co ^ sub;

`ifdef ALU_RESULT_SAT_EN
  always_comb begin
    r_fin = r;
    if (v_in) r_fin = xs ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
  end
`else
  assign r_fin = r;
`endif

  // z and n follow the value actually delivered (post-saturation)
  assign ent_in = {r_fin, ~|r_fin, r_fin[n-1], c_in, v_in};

  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    pop_skid   = 1'b0;
    case (state)
      EMPTY: if (acc) begin
        load_main  = 1'b1;
        state_next = ONE;
      end
      ONE: begin
        if (acc && dlv) begin
          load_main = 1'b1;
        end else if (acc) begin
          load_skid  = 1'b1;
          state_next = TWO;
        end else if (dlv) begin
          state_next = EMPTY;
        end
      end
      TWO: if (dlv) begin
        pop_skid   = 1'b1;
        state_next = ONE;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
      count    <= '0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != TWO);
      if (load_main)     main_q <= ent_in;
      else if (pop_skid) main_q <= skid_q;
      if (load_skid)     skid_q <= ent_in;
      if (dlv)           count  <= count + 16'd1;
    end
  end

  assign out_valid = (state != EMPTY);
  assign {res, flag_z, flag_n, flag_c, flag_v} = main_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_alu_result_stage;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, co = 1'b0, xs = 1'b0, ys = 1'b0, sub = 1'b0, out_ready = 1'b0;
  logic [7:0]  r = 8'h00;
  logic        in_ready, out_valid, flag_z, flag_n, flag_c, flag_v;
  logic [7:0]  res;
  logic [15:0] count;

  int          errors = 0, checks = 0;
  logic [11:0] q[$];
  int unsigned cnt_model = 0;
  bit          rdy_en = 0;

  alu_result_stage #(.n(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .co(co), .r(r), .xs(xs), .ys(ys), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_entry(input logic [7:0] rv, input logic cv, xv, yv, sv);
    logic       ov;
    logic [7:0] rr;
    ov = (xv == yv) && (rv[7] != xv);
    rr = rv;
`ifdef ALU_RESULT_SAT_EN
    if (ov) rr = xv ? 8'h80 : 8'h7F;
`endif
    return {rr, (rr == 8'h00), rr[7], cv ^ sv, ov};
  endfunction

  // Drive one cycle of stimulus, advance the model at the edge, return at the next negedge.
  task automatic step(input logic iv, input logic [7:0] rv, input logic cv, xv, yv, sv, ordy);
    bit acc, dlv;
    in_valid = iv; r = rv; co = cv; xs = xv; ys = yv; sub = sv; out_ready = ordy;
    acc = iv && rdy_en && (q.size() < 2);
    dlv = ordy && (q.size() > 0);
    @(posedge clk);
    if (dlv) begin void'(q.pop_front()); cnt_model++; end
    if (acc) q.push_back(ref_entry(rv, cv, xv, yv, sv));
    rdy_en = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_hs: got valid/ready=%b%b want 00", out_valid, in_ready);
    end
    checks++;
    if ({res, flag_z, flag_n, flag_c, flag_v, count} !== 28'h0) begin
      errors++; $display("FAIL reset_data: got res=%h flags=%b%b%b%b count=%h want all zero",
                         res, flag_z, flag_n, flag_c, flag_v, count);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_rel_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rdy_en = 1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_first_edge: got %b want 1", in_ready); end
  endtask

  task automatic test_overflow();
    step(1, 8'h80, 0, 0, 0, 0, 0);
    checks++;
`ifdef ALU_RESULT_SAT_EN
    if ({out_valid, res, flag_z, flag_n, flag_c, flag_v} !== {1'b1, 8'h7F, 4'b0001}) begin
      errors++; $display("FAIL overflow_sat: got v=%b res=%h zncv=%b%b%b%b want 1 7f 0001",
                         out_valid, res, flag_z, flag_n, flag_c, flag_v);
    end
`else
    if ({out_valid, res, flag_z, flag_n, flag_c, flag_v} !== {1'b1, 8'h80, 4'b0101}) begin
      errors++; $display("FAIL overflow_wrap: got v=%b res=%h zncv=%b%b%b%b want 1 80 0101",
                         out_valid, res, flag_z, flag_n, flag_c, flag_v);
    end
`endif
    step(0, 8'h00, 0, 0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL overflow_drain: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_subtract();
    step(1, 8'h00, 1, 0, 1, 1, 0);
    checks++;
    if ({out_valid, res, flag_z, flag_n, flag_c, flag_v} !== {1'b1, 8'h00, 4'b1000}) begin
      errors++; $display("FAIL sub_5_5: got v=%b res=%h zncv=%b%b%b%b want 1 00 1000",
                         out_valid, res, flag_z, flag_n, flag_c, flag_v);
    end
    step(0, 8'h00, 0, 0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    int unsigned base;
    base = cnt_model;
    step(1, 8'h11, 0, 0, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0, 0, 0);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: in_ready got %b want 0", in_ready); end
    step(1, 8'h33, 0, 0, 0, 0, 0);
    checks++;
    if ({out_valid, res, in_ready} !== {1'b1, 8'h11, 1'b0}) begin
      errors++; $display("FAIL bp_hold: got v=%b res=%h rdy=%b want 1 11 0", out_valid, res, in_ready);
    end
    step(1, 8'h33, 0, 0, 0, 0, 1);
    checks++;
    if ({out_valid, res, in_ready} !== {1'b1, 8'h22, 1'b1}) begin
      errors++; $display("FAIL bp_second: got v=%b res=%h rdy=%b want 1 22 1", out_valid, res, in_ready);
    end
    step(1, 8'h33, 0, 0, 0, 0, 1);
    checks++;
    if ({out_valid, res} !== {1'b1, 8'h33}) begin
      errors++; $display("FAIL bp_third: got v=%b res=%h want 1 33", out_valid, res);
    end
    step(0, 8'h00, 0, 0, 0, 0, 1);
    checks++;
    if ({out_valid, count} !== {1'b0, 16'(base + 3)}) begin
      errors++; $display("FAIL bp_count: got v=%b count=%h want 0 %h", out_valid, count, 16'(base + 3));
    end
  endtask

  task automatic test_throughput();
    for (int i = 0; i < 10; i++) begin
      step(1, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || {res, flag_z, flag_n, flag_c, flag_v} !== q[0]
          || count !== 16'(cnt_model)) begin
        errors++; $display("FAIL tput_%0d: got rdy=%b v=%b ent=%h cnt=%h want 1 1 %h %h",
                           i, in_ready, out_valid, {res, flag_z, flag_n, flag_c, flag_v}, count,
                           q[0], 16'(cnt_model));
      end
    end
    step(0, 8'h00, 0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0));
      checks++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || count !== 16'(cnt_model)
          || (q.size() > 0 && {res, flag_z, flag_n, flag_c, flag_v} !== q[0])) begin
        errors++; $display("FAIL rand_%0d: got v=%b rdy=%b ent=%h cnt=%h want depth=%0d head=%h cnt=%h",
                           i, out_valid, in_ready, {res, flag_z, flag_n, flag_c, flag_v}, count,
                           q.size(), (q.size() > 0) ? q[0] : 12'h0, 16'(cnt_model));
      end
    end
    while (q.size() > 0) step(0, 8'h00, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    step(1, 8'hA5, 0, 0, 0, 0, 0);
    step(1, 8'h5A, 0, 0, 0, 0, 0);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_two: in_ready got %b want 0", in_ready); end
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({out_valid, in_ready, count} !== 18'h0) begin
      errors++; $display("FAIL mid_async: got v=%b rdy=%b cnt=%h want 0 0 0000", out_valid, in_ready, count);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    q.delete(); cnt_model = 0; rdy_en = 0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_release: in_ready got %b want 0", in_ready); end
    @(negedge clk);
    rdy_en = 1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL mid_recover: got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    while (cnt_model < 65536 && guard < 70000) begin
      step(1, 8'($urandom), 0, 0, 0, 0, 1);
      guard++;
    end
    checks++;
    if (cnt_model != 65536) begin
      errors++; $display("FAIL wrap_timeout: got %0d deliveries want 65536", cnt_model);
    end
    checks++;
    if (count !== 16'h0000) begin errors++; $display("FAIL wrap_count: got %h want 0000", count); end
    while (q.size() > 0) step(0, 8'h00, 0, 0, 0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_subtract();
    test_backpressure();
    test_throughput();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage directly downstream of the n-bit ripple adder in the ALU datapath. Captures the adder's sum and carry-out, derives the zero, negative, carry/borrow and signed-overflow flags, and presents them to the next consumer over a valid/ready handshake. A two-entry skid buffer keeps full throughput under backpressure, and a wrapping counter tracks delivered results.

## Interface
- `n`, 8: datapath width; matches the adder width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  upstream result valid.
- `in_ready`  out  1  stage can accept a result.
- `co`  in  1  adder carry-out.
- `r`  in  n  adder sum.
- `xs`  in  1  sign bit of x as presented to the adder.
- `ys`  in  1  sign bit of y as presented to the adder (already inverted for subtract).
- `sub`  in  1  operation was a subtraction.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `res`  out  n  registered result.
- `flag_z`, `flag_n`, `flag_c`, `flag_v`  out  1 each  zero, negative, carry/borrow, signed overflow.
- `count`  out  16  number of results delivered, wraps.

## Operation
- Accept when `in_valid & in_ready`; deliver when `out_valid & out_ready`.
- Flags are computed on input, before registering:
  - v = (xs == ys) & (r[n-1] != xs).
  - c = co ^ sub, so c = 1 means borrow for a subtract.
  - n = final res[n-1].
  - z = (final res == 0).
- Storage is a main register and a skid register, each holding res plus the four flags. The state machine is:
  - EMPTY: out_valid=0, in_ready=1. An accept loads main and moves to ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept and deliver together: load main, stay in ONE.
    - Accept without deliver: load skid, go to TWO.
    - Deliver without accept: go to EMPTY.
  - TWO: out_valid=1, in_ready=0. A deliver moves skid into main and goes to ONE. No accept is possible in this state.
- Ordering is strict FIFO. No result is dropped or duplicated.
- `count` increments by 1 on each deliver and wraps from 0xFFFF to 0x0000.
- Outputs are stable while `out_valid & ~out_ready`.

## Timing
- Reset (async, while rst_n=0): state EMPTY; out_valid=0, in_ready=0, res=0, all flags 0, count=0.
  - in_ready rises to 1 at the first clk edge after rst_n deasserts.
- Latency: an accept at edge k presents the result on out_valid/res after edge k, i.e. one cycle. Throughput is 1 per cycle while out_ready=1.
- in_ready is a registered signal. It is low for exactly the cycles spent in TWO.
- Reset asserted mid-operation (any state) clears everything immediately. Buffered results are discarded, and count is not incremented for them.

## Configuration
- `ALU_RESULT_SAT_EN`, defined: on v=1, res saturates.
  - xs=0 → 0 followed by ones (0x7F for n=8).
  - xs=1 → 1 followed by zeros (0x80).
  - flag_v still reads 1. flag_n and flag_z are computed on the saturated value.
- Undefined: res = r unmodified (wrap-around). Flags are as above.

## Test plan
- Signed overflow, n=8: r=0x80, co=0, xs=0, ys=0, sub=0 → one cycle later:
  - Without SAT: res=0x80, v=1, n=1, z=0, c=0.
  - With SAT: res=0x7F, n=0.
- Subtract 5−5: r=0x00, co=1, xs=0, ys=1, sub=1 → res=0x00, z=1, c=0, v=0, n=0.
- Backpressure: out_ready=0, send beats A=0x11, B=0x22 → in_ready=0 after B accepted while C=0x33 is held upstream. Then raise out_ready → delivered A, B, C in order; count=3.
- Full throughput: 10 back-to-back beats with out_ready=1 → 10 deliveries on consecutive cycles; in_ready stays 1.
- Reset mid-operation: reach TWO, pulse rst_n low between edges → out_valid=0, in_ready=0, count=0 immediately; in_ready=1 one edge after release.
- Counter wrap: 65536 deliveries → count=0x0000.
